shift_exec_pipe: RTL
====================

// Module: shift_exec_pipe
// PURPOSE
//  Two-stage execute wrapper around the 16-bit SLL/SRA shifter datapath.
//  Stage 1 (S1) registers decoded shift ops from decode and drives the shifter's
//  Shift_In/Shift_Val/Mode inputs. Stage 2 (S2) captures Shift_Out, computes zero,
//  and presents the result to writeback with valid/ready backpressure.
//  It also owns the architectural Z flag for shift instructions.
// PARAMETERS
//  DATA_W   16       datapath width; must match shifter width
//  SHAMT_W  4        shift-amount width
//  OPC_SLL  4'b0100  opcode for logical left shift (Mode=0)
//  OPC_SRA  4'b0101  opcode for arithmetic right shift (Mode=1)
// PORTS
//  clk        in   1        single clock; all state updates on rising edge
//  rst        in   1        asynchronous, active-high reset
//  flush      in   1        synchronous kill of all in-flight ops
//  in_valid   in   1        decode presents an op
//  in_ready   out  1        stage can accept the op this cycle
//  in_opcode  in   4        OPC_SLL / OPC_SRA; any other value is illegal
//  in_data    in   DATA_W   operand to shift
//  in_imm     in   SHAMT_W  shift amount
//  in_dst     in   4        destination register index
//  sh_in      out  DATA_W   to shifter Shift_In
//  sh_val     out  SHAMT_W  to shifter Shift_Val
//  sh_mode    out  1        to shifter Mode (0=SLL, 1=SRA)
//  sh_out     in   DATA_W   from shifter Shift_Out (combinational from sh_*)
//  out_valid  out  1        S2 holds a result
//  out_ready  in   1        writeback accepts the result
//  out_data   out  DATA_W   shifted result
//  out_dst    out  4        destination register index
//  out_z      out  1        1 when out_data == 0
//  z_flag     out  1        architectural Z flag
//  illegal    out  1        one-cycle pulse: an illegal opcode was accepted
// BEHAVIOUR
//  Reset (async, immediate):
//   - S1/S2 valid=0; all data/dst/z registers=0.
//   - z_flag=0, illegal=0; hence out_*=0 and sh_*=0.
//  Handshakes:
//   - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  Advance rules:
//   - s2_free = !v2 | out_ready.
//   - S1 advances to S2 when v1 & s2_free.
//   - in_ready = !flush & (!v1 | (v1 & s2_free)); this is 1 out of reset.
//  Shifter drive:
//   - sh_in/sh_val/sh_mode = S1 registers when v1=1, else 0.
//   - S2 captures sh_out on the same edge S1 advances.
//  Latency and throughput:
//   - Op accepted at edge N is on out_valid after edge N+1 (2-cycle latency).
//   - Throughput is 1 op/cycle when out_ready stays 1.
//  Stall:
//   - While out_valid & !out_ready, out_data/out_dst/out_z hold stable.
//   - S1 holds its op; in_ready=0 when S1 is also full.
//   - Order is strictly FIFO; no op is dropped or duplicated.
//  Zero and flag:
//   - out_z = (captured result == 0), registered with the result.
//   - z_flag <= out_z on out_fire only; otherwise z_flag holds.
//  Illegal opcode:
//   - An illegal op with in_fire is consumed but not loaded into S1.
//   - illegal=1 for exactly the next cycle; otherwise illegal=0.
//  Flush (priority over everything but reset):
//   - Next edge: v1=0, v2=0, illegal=0, z_flag unchanged.
//   - An out_fire in the flush cycle does not update z_flag.
//  Simultaneous events:
//   - Same-cycle out_fire and S1->S2 advance: S2 reloads with no bubble.
//   - Same-cycle in_fire and S1 advance: S1 reloads with no bubble.
//  Mid-operation reset: all in-flight ops lost; outputs return to reset values.
//  Width rules:
//   - No arithmetic beyond the zero compare.
//   - Shift amount is passed through unmodified; 0 yields the operand unchanged.
// TESTING
//  1. SLL data=0x0001 imm=4, out_ready=1 -> 2 cycles later out_data=0x0010, out_z=0, z_flag=0.
//  2. SRA data=0x8000 imm=15 -> out_data=0xFFFF; SRA data=0x4000 imm=14 -> 0x0001.
//  3. SLL data=0x8000 imm=1 -> out_data=0x0000, out_z=1; z_flag=1 the cycle after out_fire.
//  4. 3 back-to-back ops, out_ready=0 for 4 cycles:
//     - in_ready=0 after 2 accepts; out_data stable.
//     - Release out_ready -> all 3 emerge in order.
//  5. Flush with S1 and S2 full -> next cycle out_valid=0, in_ready=1, z_flag unchanged.
//  6. Illegal opcode 4'b0000 -> illegal pulses 1 cycle, no out_valid.
//     Assert rst mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/shift_exec_pipe.sv
// Two-stage execute wrapper for the 16-bit SLL/SRA shifter.
// S1 drives the shifter, S2 holds the result for writeback and owns Z.
module shift_exec_pipe #(
   parameter int          DATA_W  = 16,
   parameter int          SHAMT_W = 4,
   parameter logic [3:0]  OPC_SLL = 4'b0100,
   parameter logic [3:0]  OPC_SRA = 4'b0101
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_opcode,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [SHAMT_W-1:0] in_imm,
   input  logic [3:0]         in_dst,
   output logic [DATA_W-1:0]  sh_in,
   output logic [SHAMT_W-1:0] sh_val,
   output logic               sh_mode,
   input  logic [DATA_W-1:0]  sh_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [3:0]         out_dst,
   output logic               out_z,
   output logic               z_flag,
   output logic               illegal
);

   logic               v1;
   logic [DATA_W-1:0]  s1_data;
   logic [SHAMT_W-1:0] s1_imm;
   logic               s1_mode;
   logic [3:0]         s1_dst;

   logic               v2;
   logic [DATA_W-1:0]  s2_data;
   logic [3:0]         s2_dst;
   logic               s2_z;

   logic s2_free;
   logic adv;
   logic in_fire;
   logic out_fire;
   logic op_sll;
   logic op_sra;
   logic legal;

   assign s2_free  = !v2 || out_ready;
   assign adv      = v1 && s2_free;
   assign in_ready = !flush && (!v1 || adv);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = v2 && out_ready;

   assign op_sll = (in_opcode == OPC_SLL);
   assign op_sra = (in_opcode == OPC_SRA);
   assign legal  = op_sll || op_sra;

   // Shifter inputs are forced to zero whenever S1 is empty.
   assign sh_in   = v1 ? s1_data : '0;
   assign sh_val  = v1 ? s1_imm  : '0;
   assign sh_mode = v1 && s1_mode;

   assign out_valid = v2;
   assign out_data  = s2_data;
   assign out_dst   = s2_dst;
   assign out_z     = s2_z;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1      <= 1'b0;
         s1_data <= '0;
         s1_imm  <= '0;
         s1_mode <= 1'b0;
         s1_dst  <= '0;
      end else if (flush) begin
         v1 <= 1'b0;
      end else if (in_fire && legal) begin
         v1      <= 1'b1;
         s1_data <= in_data;
         s1_imm  <= in_imm;
         s1_mode <= op_sra;
         s1_dst  <= in_dst;
      end else if (adv) begin
         v1 <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2      <= 1'b0;
         s2_data <= '0;
         s2_dst  <= '0;
         s2_z    <= 1'b0;
      end else if (flush) begin
         v2 <= 1'b0;
      end else if (adv) begin
         v2      <= 1'b1;
         s2_data <= sh_out;
         s2_dst  <= s1_dst;
         s2_z    <= (sh_out == '0);
      end else if (out_fire) begin
         v2 <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z_flag  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         illegal <= !flush && in_fire && !legal;
         if (!flush && out_fire) begin
            z_flag <= s2_z;
         end
      end
   end

endmodule
